display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment display bank. It holds a frame of BCD digits and shares a single BCD-to-segment decoder across `N_DIGITS` digits by cycling the digit enables. It sits between the counter/adder datapath, which supplies packed BCD, and the display pins. New values are accepted through a one-cycle update strobe and applied only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits (2..8)
- `SCAN_DIV`, 50000: clock cycles per digit slot
- `DEAD_CYC`, 2: blank cycles at the start of each slot; requires `SCAN_DIV > DEAD_CYC`
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `digitos` in 4*N_DIGITS: packed BCD, digit 0 (least significant) at [3:0]
- `atualiza` in 1: one-cycle strobe that captures `digitos` into the pending buffer
- `anodo` out 7: segment pattern, active-low, bit 6 = g … bit 0 = a
- `sel_an` out N_DIGITS: digit enables, active-low, one-hot-low or all high
- `frame_done` out 1: one-cycle pulse at frame wrap
- `pendente` out 1: pending buffer holds an update not yet displayed

## Operation
- Registers:
  - `pend_buf`/`pendente`: captured data and its valid flag.
  - `shadow`: frame currently displayed.
  - `idx`: digit index, 0..N_DIGITS-1.
  - `cnt`: slot counter, 0..SCAN_DIV-1.
  - `state`: one of `BLANK`, `ON`.
- FSM:
  - `BLANK`: `sel_an` all 1 and `anodo` = 7'b1111111. Go to `ON` when `cnt == DEAD_CYC-1`.
  - `ON`: `sel_an[idx] = 0` and `anodo` = decode(`shadow[idx]`).
  - At `cnt == SCAN_DIV-1`: set `cnt` to 0, advance `idx`, return to `BLANK`.
- Wrap: when `idx == N_DIGITS-1` and the slot ends:
  - `idx` goes to 0 and `frame_done` pulses.
  - If `pendente` is set: `shadow <= pend_buf` and `pendente` clears.
- Update: `atualiza` loads `pend_buf <= digitos` and sets `pendente`. A later strobe before the wrap overwrites the earlier one; the last strobe wins.
- Simultaneous `atualiza` and wrap: `shadow` loads `digitos` directly (bypass), `pend_buf` also loads, and `pendente` ends at 0.
- Invalid BCD (>9) in `shadow[idx]`: the digit is driven blank (7'b1111111) while `sel_an` is still asserted. No error flag.
- Decode map (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Reset values:
  - `state = BLANK`, `idx = 0`, `cnt = 0`.
  - `shadow = 0`, `pend_buf = 0`, `pendente = 0`.
  - `sel_an` all 1, `anodo = 7'b1111111`, `frame_done = 0`.
- Reset asserted mid-slot or mid-update: all state returns to reset values immediately and any pending update is discarded.

## Timing
- All outputs are registered. `anodo` and `sel_an` change on the same edge, so a wrong-digit glitch cannot occur.
- Slot = `SCAN_DIV` cycles: `DEAD_CYC` cycles blank, then `SCAN_DIV-DEAD_CYC` cycles on. Frame = `N_DIGITS*SCAN_DIV` cycles.
- First enable after reset release: `sel_an[0]` falls at cycle `DEAD_CYC`, counted from the first active edge.
- `frame_done` is high on the first `BLANK` cycle of digit 0 of the new frame.
- Update latency: a value strobed at any point is displayed from the start of the next frame, at most one frame plus one slot later.
- `pendente` rises the cycle after `atualiza` and falls the cycle after the wrap.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digit k (k ≥ 1) is blanked when it and every higher digit of `shadow` are 0. Digit 0 is always shown. Blanked digits keep `sel_an` high for their whole slot, and slot timing is unchanged.
- `LEADING_ZERO_BLANK_EN` undefined: all digits are displayed, including leading zeros.

## Structure
- The shared package holds:
  - `SEG_BLANK` = 7'b1111111
  - the digit-to-pattern constant table used by the decoder
  - the `BLANK`/`ON` state encoding
- One sub-module: `scan_prescaler`, which owns `cnt` and produces `dead_end` and `slot_end` ticks. Decoding reuses the existing `bcd_to_display` instance, with the blank override muxed after it.

## Test plan
- Reset, scan order: `SCAN_DIV=4`, `DEAD_CYC=1`, `N_DIGITS=4`; strobe `digitos=16'h4321` and wait one frame.
  - Expect repeating patterns 1111001, 0100100, 0110000, 0011001, with `sel_an` = 1110, 1101, 1011, 0111.
  - Each slot shows 1 blank cycle then 3 on cycles, and `frame_done` pulses every 16 cycles.
- Mid-frame update: strobe `16'h9999` during digit 1 of a frame showing 1234. The rest of that frame still shows 1234, the next frame shows 9 on every digit, and `pendente` is high until the wrap.
- Collision: assert `atualiza` with `16'h0008` on the wrap cycle. The new frame shows 8 on digit 0 and `pendente` stays 0.
- Invalid BCD: strobe `16'h00A5`. Digit 1 slot shows `anodo = 1111111` with `sel_an = 1101`, and digit 0 shows 0010010.
- `LEADING_ZERO_BLANK_EN`: strobe `16'h0070`. Digits 3 and 2 keep `sel_an` high for their whole slot, digit 1 shows 1111000 and digit 0 shows 1000000. Without the macro, all four digits are displayed.
- Reset mid-operation: assert `rst_n=0` in digit 2 ON with `pendente=1`. All outputs go to reset values immediately and the pending update is lost after release.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller:
// blank pattern, BCD segment table and scan FSM encoding.
package display_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000
  };

  typedef enum logic {
    BLANK,
    ON
  } scan_st_e;

endpackage

// File: rtl/display_scan_ctrl_decode.sv
// bcd_to_display: active-low BCD to segment decoder,
// non-BCD codes map to the blank pattern.
module bcd_to_display
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = (i_bcd <= 4'd9) ?
    SEG_LUT[i_bcd] : SEG_BLANK;

endmodule

// File: rtl/display_scan_ctrl_prescaler.sv
// scan_prescaler: slot counter 0..SCAN_DIV-1 with
// end-of-dead-time and end-of-slot ticks.
module scan_prescaler #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_dead_end,
  output logic o_slot_end
);

  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_dead_end = (r_cnt == CW'(DEAD_CYC - 1));
  assign o_slot_end = (r_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cnt <= '0;
    else if (o_slot_end) r_cnt <= '0;
    else                 r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scan with frame-aligned
// updates; optional LEADING_ZERO_BLANK_EN hides leading zero digits.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digitos,
  input  logic                  atualiza,
  output logic [6:0]            anodo,
  output logic [N_DIGITS-1:0]   sel_an,
  output logic                  frame_done,
  output logic                  pendente
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;

  scan_st_e            r_state;
  logic [IW-1:0]       r_idx;
  logic [DW-1:0]       r_shadow;
  logic [DW-1:0]       r_pend_buf;
  logic                r_pend;
  logic                r_frame_done;
  logic [6:0]          r_anodo;
  logic [N_DIGITS-1:0] r_sel_an;

  logic                w_dead_end;
  logic                w_slot_end;
  logic                w_last;
  logic                w_hide;
  logic [3:0]          w_digit;
  logic [6:0]          w_dec;
  logic [6:0]          w_seg_on;
  logic [N_DIGITS-1:0] w_sel_on;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_presc (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_dead_end (w_dead_end),
    .o_slot_end (w_slot_end)
  );

  assign w_digit = r_shadow[4*r_idx +: 4];

  bcd_to_display u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_lz;
  logic                w_hi_zero;

  // w_lz[k]: digit k and everything above it are zero
  always_comb begin
    w_lz      = '0;
    w_hi_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_hi_zero = w_hi_zero &
        (r_shadow[4*k +: 4] == 4'd0);
      w_lz[k]   = w_hi_zero;
    end
  end

  assign w_hide = w_lz[r_idx];
`else
  assign w_hide = 1'b0;
`endif

  assign w_last   = (r_idx == IW'(N_DIGITS - 1));
  assign w_sel_on = w_hide ? '1 :
    ~(N_DIGITS'(1) << r_idx);
  assign w_seg_on = (w_hide || w_digit > 4'd9) ?
    SEG_BLANK : w_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BLANK;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_pend_buf   <= '0;
      r_pend       <= 1'b0;
      r_frame_done <= 1'b0;
      r_anodo      <= SEG_BLANK;
      r_sel_an     <= '1;
    end else begin
      r_frame_done <= 1'b0;
      if (atualiza) begin
        r_pend_buf <= digitos;
        r_pend     <= 1'b1;
      end
      unique case (r_state)
        BLANK: begin
          if (w_dead_end) begin
            r_state  <= ON;
            r_sel_an <= w_sel_on;
            r_anodo  <= w_seg_on;
          end
        end
        ON: begin
          r_sel_an <= w_sel_on;
          r_anodo  <= w_seg_on;
          if (w_slot_end) begin
            r_state  <= BLANK;
            r_sel_an <= '1;
            r_anodo  <= SEG_BLANK;
            r_idx    <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_pend       <= 1'b0;
              // a strobe on the wrap edge bypasses the buffer
              if (atualiza)    r_shadow <= digitos;
              else if (r_pend) r_shadow <= r_pend_buf;
            end
          end
        end
        default: r_state <= BLANK;
      endcase
    end
  end

  assign anodo      = r_anodo;
  assign sel_an     = r_sel_an;
  assign frame_done = r_frame_done;
  assign pendente   = r_pend;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench, 4 digits, SCAN_DIV=4,
// DEAD_CYC=1; every cycle checked against a frame model.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int FR = N * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digitos = '0;
  logic        atualiza = 1'b0;
  logic [6:0]  anodo;
  logic [3:0]  sel_an;
  logic        frame_done;
  logic        pendente;

  int n_chk = 0;
  int n_ok  = 0;
  int e     = 0;

  logic [15:0] m_sh = '0;
  logic [15:0] m_pb = '0;
  logic        m_pend = 1'b0;

  display_scan_ctrl #(
    .N_DIGITS (N),
    .SCAN_DIV (SD),
    .DEAD_CYC (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digitos    (digitos),
    .atualiza   (atualiza),
    .anodo      (anodo),
    .sel_an     (sel_an),
    .frame_done (frame_done),
    .pendente   (pendente)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s @%0d: got %0h want %0h",
                  tag, e, got, exp);
  endtask

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic bit lz(input logic [15:0] f, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < N; j++)
      if (f[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outs();
    int c;
    int ix;
    logic [3:0] dg;
    logic [3:0] es;
    logic [6:0] ea;
    c  = e % SD;
    ix = (e / SD) % N;
    dg = m_sh[4*ix +: 4];
    es = 4'hF;
    ea = 7'h7F;
    if (c >= DC && !lz(m_sh, ix)) begin
      es = ~(4'b0001 << ix);
      ea = seg(dg);
    end
    check("sel_an", 32'(sel_an), 32'(es));
    check("anodo", 32'(anodo), 32'(ea));
    check("frame_done", 32'(frame_done),
          32'(e > 0 && e % FR == 0));
    check("pendente", 32'(pendente), 32'(m_pend));
  endtask

  task automatic cyc(input bit a, input logic [15:0] d);
    atualiza = a;
    digitos  = d;
    @(posedge clk);
    #1;
    atualiza = 1'b0;
    e++;
    if (e % FR == 0) begin
      if (a) m_sh = d;
      else if (m_pend) m_sh = m_pb;
      m_pend = 1'b0;
      if (a) m_pb = d;
    end else if (a) begin
      m_pb   = d;
      m_pend = 1'b1;
    end
    check_outs();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", 32'(sel_an), 32'h0F);
    check("rst_seg", 32'(anodo), 32'h7F);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_pend", 32'(pendente), 32'h0);
    rst_n = 1'b1;
    check_outs();

    // scan order with 4321
    cyc(1'b1, 16'h4321);
    idle(15);
    idle(16);
    cyc(1'b0, 16'h0000);
    check("t1_d0_seg", 32'(anodo), 32'h79);
    check("t1_d0_sel", 32'(sel_an), 32'hE);

    // mid-frame update on a frame showing 1234
    cyc(1'b1, 16'h1234);
    idle(14);
    idle(5);
    cyc(1'b1, 16'h9999);
    check("mid_pend", 32'(pendente), 32'h1);
    check("mid_old", 32'(anodo), 32'(7'b0110000));
    idle(10);
    check("mid_wrap_pend", 32'(pendente), 32'h0);
    cyc(1'b0, 16'h0000);
    check("mid_new", 32'(anodo), 32'(7'b0010000));

    // strobe on the wrap edge
    idle(14);
    cyc(1'b1, 16'h0008);
    check("col_pend", 32'(pendente), 32'h0);
    check("col_fd", 32'(frame_done), 32'h1);
    cyc(1'b0, 16'h0000);
    check("col_seg", 32'(anodo), 32'(7'b0000000));

    // invalid BCD in digit 1
    cyc(1'b1, 16'h00A5);
    idle(14);
    cyc(1'b0, 16'h0000);
    check("inv_d0_seg", 32'(anodo), 32'(7'b0010010));
    idle(4);
    check("inv_d1_seg", 32'(anodo), 32'h7F);
    check("inv_d1_sel", 32'(sel_an), 32'hD);

    // leading zeros
    cyc(1'b1, 16'h0070);
    idle(10);
    cyc(1'b0, 16'h0000);
    check("lz_d0", 32'(anodo), 32'(7'b1000000));
    idle(3);
    cyc(1'b0, 16'h0000);
    check("lz_d1", 32'(anodo), 32'(7'b1111000));
    idle(7);
    cyc(1'b0, 16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d3_sel", 32'(sel_an), 32'hF);
`else
    check("lz_d3_sel", 32'(sel_an), 32'h7);
`endif
    idle(3);

    // reset during digit 2 ON with an update pending
    cyc(1'b1, 16'h5555);
    idle(8);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_sel", 32'(sel_an), 32'h0F);
    check("rm_seg", 32'(anodo), 32'h7F);
    check("rm_fd", 32'(frame_done), 32'h0);
    check("rm_pend", 32'(pendente), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    e      = 0;
    m_sh   = '0;
    m_pb   = '0;
    m_pend = 1'b0;
    idle(17);
    check("rm_lost", 32'(anodo), 32'(7'b1000000));

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
